// File: rtl/fifo_gather_wide.sv
// Gathering FIFO: RATIO narrow W_IN-bit writes form one wide entry, DEPTH entries buffered FWFT.
// Optional partial-entry flush enabled by defining FIFO_GATHER_FLUSH_EN.
module fifo_gather_wide #(
    parameter int W_IN  = 16,
    parameter int RATIO = 2,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W_IN-1:0]            i_wr_data,
    input  logic                       i_wr_en,
    input  logic                       i_flush,
    output logic                       o_full,
    output logic [W_IN*RATIO-1:0]      o_rd_data,
    output logic [RATIO-1:0]           o_rd_mask,
    input  logic                       i_rd_en,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int W_OUT = W_IN * RATIO;
    localparam int LW    = $clog2(RATIO);
    localparam int FW    = LW + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef FIFO_GATHER_FLUSH_EN
    localparam int RW    = W_OUT + RATIO;
`else
    localparam int RW    = W_OUT;
`endif
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    logic [LW-1:0]    lane_q, lane_d;
    logic [W_OUT-1:0] acc_q, acc_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic [RW-1:0]    mem_q [DEPTH];

    logic [W_OUT-1:0] acc_wr_s;
    logic [W_OUT-1:0] push_data_s;
    logic [FW-1:0]    filled_s;
    logic [RATIO-1:0] mask_s;
    logic [RW-1:0]    wr_entry_s;
    logic [RW-1:0]    rd_entry_s;
    logic             push_s, pop_s, flush_s;

`ifdef FIFO_GATHER_FLUSH_EN
    assign flush_s    = i_flush;
    assign wr_entry_s = {push_data_s, mask_s};
    assign o_rd_data  = rd_entry_s[RW-1 -: W_OUT];
    assign o_rd_mask  = rd_entry_s[RATIO-1:0];
`else
    logic unused_s;
    assign flush_s    = 1'b0;
    assign unused_s   = ^{i_flush, mask_s};
    assign wr_entry_s = push_data_s;
    assign o_rd_data  = rd_entry_s;
    assign o_rd_mask  = {RATIO{1'b1}};
`endif

    assign rd_entry_s = mem_q[rd_ptr_q];
    assign pop_s      = i_rd_en & ~empty_q;
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_count    = count_q;

    // Accumulator with the incoming word merged into the current lane (lane 0 is the MS lane)
    always_comb begin
        acc_wr_s = acc_q;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_q == LW'(k)) begin
                acc_wr_s[W_OUT-1-k*W_IN -: W_IN] = i_wr_data;
            end else begin
                acc_wr_s[W_OUT-1-k*W_IN -: W_IN] = acc_q[W_OUT-1-k*W_IN -: W_IN];
            end
        end
    end

    // Lane/accumulator next state and push decision; nothing is admitted while full
    always_comb begin
        push_s      = 1'b0;
        push_data_s = acc_wr_s;
        filled_s    = FW'(RATIO);
        lane_d      = lane_q;
        acc_d       = acc_q;
        if (!full_q) begin
            if (i_wr_en) begin
                if (lane_q == LAST_LANE) begin
                    push_s = 1'b1;
                    lane_d = '0;
                    acc_d  = '0;
                end else if (flush_s) begin
                    push_s   = 1'b1;
                    filled_s = {1'b0, lane_q} + FW'(1);
                    lane_d   = '0;
                    acc_d    = '0;
                end else begin
                    acc_d  = acc_wr_s;
                    lane_d = lane_q + LW'(1);
                end
            end else if (flush_s && (lane_q != '0)) begin
                push_s      = 1'b1;
                push_data_s = acc_q;
                filled_s    = {1'b0, lane_q};
                lane_d      = '0;
                acc_d       = '0;
            end else begin
                lane_d = lane_q;
            end
        end else begin
            lane_d = lane_q;
        end
    end

    // Lane mask: the top 'filled' bits are valid lanes
    always_comb begin
        mask_s = '0;
        for (int k = 0; k < RATIO; k++) begin
            mask_s[RATIO-1-k] = (FW'(k) < filled_s);
        end
    end

    // Occupancy next state
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q   <= '0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            lane_q  <= lane_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Entry storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_entry_s;
        end
    end

endmodule

// File: tb/tb_fifo_gather_wide.sv
// Self-checking bench for fifo_gather_wide (W_IN=16, RATIO=2, DEPTH=16): vector table,
// directed corner sequences and randomized traffic against a queue-based reference model.
module tb_fifo_gather_wide;

    localparam int W_IN  = 16;
    localparam int RATIO = 2;
    localparam int DEPTH = 16;
    localparam int W_OUT = W_IN * RATIO;
`ifdef FIFO_GATHER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [W_IN-1:0]   wr_data = '0;
    logic              wr_en = 1'b0;
    logic              flush = 1'b0;
    logic              rd_en = 1'b0;
    logic              full, empty;
    logic [W_OUT-1:0]  rd_data;
    logic [RATIO-1:0]  rd_mask;
    logic [4:0]        count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    fifo_gather_wide #(.W_IN(W_IN), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_wr_data(wr_data), .i_wr_en(wr_en), .i_flush(flush),
        .o_full(full), .o_rd_data(rd_data), .o_rd_mask(rd_mask), .i_rd_en(rd_en),
        .o_empty(empty), .o_count(count)
    );

    always #5 clk = ~clk;

    // Reference model: list of stored entries plus list of gathered narrow words
    logic [W_OUT-1:0] mq_d [$];
    logic [RATIO-1:0] mq_m [$];
    logic [W_IN-1:0]  part [$];

    task automatic model_push_part();
        logic [W_OUT-1:0] d;
        logic [RATIO-1:0] m;
        d = '0;
        m = '0;
        for (int i = 0; i < part.size(); i++) begin
            d[W_OUT-1-i*W_IN -: W_IN] = part[i];
            m[RATIO-1-i] = 1'b1;
        end
        mq_d.push_back(d);
        mq_m.push_back(m);
        part.delete();
    endtask

    task automatic model_step(input logic r, input logic w, input logic [W_IN-1:0] d,
                              input logic rd, input logic fl);
        bit was_full, was_empty;
        if (r) begin
            mq_d.delete();
            mq_m.delete();
            part.delete();
        end else begin
            was_full  = (mq_d.size() == DEPTH);
            was_empty = (mq_d.size() == 0);
            if (rd && !was_empty) begin
                void'(mq_d.pop_front());
                void'(mq_m.pop_front());
            end
            if (!was_full) begin
                if (w) begin
                    part.push_back(d);
                    if (part.size() == RATIO || (FLUSH_EN && fl)) model_push_part();
                end else if (FLUSH_EN && fl && part.size() > 0) begin
                    model_push_part();
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle, advance the model, sample #1 after the edge
    task automatic drive(input logic r, input logic w, input logic [W_IN-1:0] d,
                         input logic rd, input logic fl);
        rst = r; wr_en = w; wr_data = d; rd_en = rd; flush = fl;
        @(posedge clk);
        model_step(r, w, d, rd, fl);
        cyc++;
        #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    task automatic cmp_model();
        chk("m_empty", empty, mq_d.size() == 0);
        chk("m_full",  full,  mq_d.size() == DEPTH);
        chk("m_count", count, mq_d.size());
        if (mq_d.size() > 0) begin
            chk("m_data", rd_data, mq_d[0]);
            chk("m_mask", rd_mask, mq_m[0]);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [W_IN-1:0] d,
                        input logic rd, input logic fl);
        drive(r, w, d, rd, fl);
        cmp_model();
    endtask

    typedef struct {
        logic             rst, wr, rd, fl;
        logic [W_IN-1:0]  wd;
        logic             e_empty, e_full;
        logic [4:0]       e_count;
        logic [W_OUT-1:0] e_data;
        logic [RATIO-1:0] e_mask;
    } vec_t;

    function automatic vec_t mkv(logic r, logic w, logic rd, logic fl, logic [W_IN-1:0] wd,
                                 logic ee, logic ef, logic [4:0] ec, logic [W_OUT-1:0] ed,
                                 logic [RATIO-1:0] em);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = rd; v.fl = fl; v.wd = wd;
        v.e_empty = ee; v.e_full = ef; v.e_count = ec; v.e_data = ed; v.e_mask = em;
        return v;
    endfunction

    vec_t vt [14];

    initial begin
        vt[0]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5'd0, 32'h0, 2'b11);
        vt[1]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b0, 5'd0, 32'h0, 2'b11);
        vt[2]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 5'd1, 32'hAAAA5555, 2'b11);
        vt[3]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 5'd1, 32'hAAAA5555, 2'b11);
        vt[4]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 16'h5678, 1'b0, 1'b0, 5'd1, 32'h12345678, 2'b11);
        vt[5]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 5'd0, 32'h0, 2'b11);
        vt[6]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 5'd0, 32'h0, 2'b11);
        vt[7]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b0, 5'd0, 32'h0, 2'b11);
`ifdef FIFO_GATHER_FLUSH_EN
        vt[8]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 5'd1, 32'hBEEF0000, 2'b10);
        vt[9]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 16'hCAFE, 1'b0, 1'b0, 5'd1, 32'hBEEF0000, 2'b10);
        vt[10] = mkv(1'b0, 1'b1, 1'b0, 1'b1, 16'hF00D, 1'b0, 1'b0, 5'd2, 32'hBEEF0000, 2'b10);
        vt[11] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5'd0, 32'h0, 2'b11);
        vt[12] = mkv(1'b0, 1'b1, 1'b0, 1'b1, 16'h7777, 1'b0, 1'b0, 5'd1, 32'h77770000, 2'b10);
`else
        vt[8]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 5'd0, 32'h0, 2'b11);
        vt[9]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 16'hCAFE, 1'b0, 1'b0, 5'd1, 32'hBEEFCAFE, 2'b11);
        vt[10] = mkv(1'b0, 1'b1, 1'b0, 1'b1, 16'hF00D, 1'b0, 1'b0, 5'd1, 32'hBEEFCAFE, 2'b11);
        vt[11] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5'd0, 32'h0, 2'b11);
        vt[12] = mkv(1'b0, 1'b1, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b0, 5'd0, 32'h0, 2'b11);
`endif
        vt[13] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5'd0, 32'h0, 2'b11);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].rst, vt[i].wr, vt[i].wd, vt[i].rd, vt[i].fl);
            chk($sformatf("vec%0d_empty", i), empty, vt[i].e_empty);
            chk($sformatf("vec%0d_full", i),  full,  vt[i].e_full);
            chk($sformatf("vec%0d_count", i), count, vt[i].e_count);
            if (!vt[i].e_empty) begin
                chk($sformatf("vec%0d_data", i), rd_data, vt[i].e_data);
                chk($sformatf("vec%0d_mask", i), rd_mask, vt[i].e_mask);
            end
        end

        // Fill to full, drop extra write, drain in order
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
        chk("fill_full", full, 1'b1);
        step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("drop_count", count, 5'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), rd_data, {16'(2*i), 16'(2*i+1)});
            step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        end
        chk("drain_empty", empty, 1'b1);

        // Steady state at 15 entries with pointer wrap
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        for (int e = 0; e < 40; e++) begin
            step(1'b0, 1'b1, 16'(16'h2000 + 2*e), 1'b0, 1'b0);
            step(1'b0, 1'b1, 16'(16'h2001 + 2*e), 1'b1, 1'b0);
            chk("steady_count", count, 5'd15);
        end

        // Reset mid-accumulation discards the pending lane
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hCAFE, 1'b0, 1'b0);
        chk("rst_mid_data", rd_data, 32'hBEEFCAFE);
        chk("rst_mid_count", count, 5'd1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("rst_mid_empty", empty, 1'b1);

        // Partial entry completing the FIFO, then flush/write while full
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 29; i++) step(1'b0, 1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h3100, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h3101, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h3102, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h3103, 1'b0, 1'b1);

        // Randomized traffic in phases biased toward fill, drain, mixed
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int ph = 0; ph < 8; ph++) begin
            int pw, pr;
            case (ph % 4)
                0:       begin pw = 90; pr = 15; end
                1:       begin pw = 25; pr = 85; end
                2:       begin pw = 60; pr = 50; end
                default: begin pw = 95; pr = 45; end
            endcase
            for (int c = 0; c < 400; c++) begin
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) < pw,
                     16'($urandom),
                     $urandom_range(0, 99) < pr,
                     $urandom_range(0, 99) < 15);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
